rv32i_single_cycle_cpu: RTL and testbench
=========================================

// Module: rv32i_single_cycle_cpu
// PURPOSE
//  Single-cycle RV32I subset core (LW, SW, ADD, AND, OR, BEQ; ADDI x0 as NOP) with internal
//  word-addressed instruction ROM and data RAM. Self-contained top: no external bus.
//  Each rising clk edge fetches, decodes and executes exactly one instruction.
// PARAMETERS
//  IMEM_WORDS  64  instruction ROM depth (32-bit words), preloaded with the program below
//  DMEM_WORDS  64  data RAM depth (32-bit words), preloaded with the image below
// PORTS
//  clk    in  1  single clock; all state updates on rising edge
//  rst_n  in  1  reset: asynchronous, active-high (asserted = 1); name kept per codebase
// BEHAVIOUR
//  - Reset: pc=0 immediately; regfile x1..x31 cleared; memories NOT reset (keep init image).
//  - First rising edge after reset release executes instr @0x00; one instruction per edge.
//  - Fetch: instr = imem[pc[31:2] mod IMEM_WORDS]; data address = word index addr[31:2] mod DMEM_WORDS;
//    addr[1:0] ignored (no misalign trap).
//  - LW  (op 0000011, f3 010): rd <= dmem[rs1+sext(I-imm)].
//  - SW  (op 0100011, f3 010): dmem[rs1+sext(S-imm)] <= rs2 at edge.
//  - R-type (op 0110011, f7 0): f3 000 ADD, 111 AND, 110 OR; rd <= rs1 op rs2, mod 2^32.
//  - BEQ (op 1100011, f3 000): pc <= (rs1==rs2) ? pc+sext(B-imm) : pc+4; backward offsets legal.
//  - OP-IMM f3 000 with rd=x0 (NOP) and every unsupported encoding: no state change except pc+4.
//  - x0 reads 0, writes to x0 discarded. Reads combinational; regfile/dmem writes at edge.
//  - Internal names fixed for bench probing: pc, regfile_u.registers[0:31], dmemory.mem[].
//  - Reset asserted mid-run: pc->0 and regs cleared at once; a store on that edge is suppressed.
//  Init dmem (word:value): 0:AEAEAEAE 1:00000000 2:ABCDEF11 3:ABCDEF11 4:F2F2F2F2
//   5:12345678 6:125F552D 7:7F4FD46A, rest 0.
//  Init imem (addr:word asm): 00:00C02903 lw x18,12(x0) | 04:01202823 sw x18,16(x0)
//   08:01402883 lw x17,20(x0) | 0C:011909B3 add x19,x18,x17 | 10:01397AB3 and x21,x18,x19
//   14:01802283 lw x5,24(x0) | 18:01C02303 lw x6,28(x0) | 1C:0062E3B3 or x7,x5,x6
//   20:00000013 nop | 24:00730663 beq x6,x7,12 | 28:00802B03 lw x22,8(x0)
//   2C:01690863 beq x18,x22,16 | 30,34:00000013 | 38:00000663 beq x0,x0,12
//   3C:00002B03 lw x22,0(x0) | 40:FF6B0CE3 beq x22,x22,-8 | 44 onward: 00000013.
// STRUCTURE
//  - Package rv32i_pkg: opcode/funct3/funct7 constants, alu_op_e enum, imm-type enum.
//  - Sub-module rv32i_regfile (instance regfile_u): 32x32, 2 async read, 1 sync write, x0=0.
//  - Decoder, immediate generator, ALU, dmemory array and pc logic live in the top.
// TESTING  (edge N = Nth rising edge after reset release; sample after edge)
//  - Reset: hold rst_n=1 -> pc=0x00000000; release, edge1 -> x18=ABCDEF11.
//  - Store: before edge2 dmem[4]=F2F2F2F2; after edge2 dmem[4]=ABCDEF11.
//  - ALU: edges 3-5 -> x17=12345678, x19=BE024589, x21=AA004501; edges 6-8 -> x5=125F552D,
//    x6=7F4FD46A, x7=7F5FD56F.
//  - NOP / BEQ not taken: edge9 -> pc=0x24; edge10 -> pc=0x28; edge11 -> x22=ABCDEF11.
//  - BEQ taken fwd/back: edge12 -> pc=0x3C; edge13 -> x22=AEAEAEAE; edge14 -> pc=0x38;
//    edge15 -> pc=0x44.
//  - Async reset mid-run: assert rst_n=1 between edges -> pc=0 without a clock edge; x0 stays 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - encodings, ALU/immediate selectors and immediate generator for the RV32I subset core
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;

    typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR} alu_op_e;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B} imm_type_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e imm_type);
        case (imm_type)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 32x32 register file, two combinational reads, one edge write, x0 hardwired to zero
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] registers [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];

endmodule

// File: rtl/rv32i_single_cycle_cpu.sv
// rtl/rv32i_single_cycle_cpu.sv - single-cycle RV32I subset core with internal program ROM and data RAM
module rv32i_single_cycle_cpu
    import rv32i_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input logic clk,
    input logic rst_n
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc, pc_d;
    logic [31:0] instr, imm, alu_b, alu_res, wb_data, load_data;
    logic [31:0] rs1_val, rs2_val;
    logic        reg_we, mem_we, is_load, is_branch, use_imm;
    alu_op_e     alu_op;
    imm_type_e   imm_type;
    logic [IAW-1:0] imem_idx;
    logic [DAW-1:0] dmem_idx;

    function automatic logic [31:0] imem_rom(input logic [IAW-1:0] idx);
        case (32'(idx))
            32'd0:   return 32'h00C02903;
            32'd1:   return 32'h01202823;
            32'd2:   return 32'h01402883;
            32'd3:   return 32'h011909B3;
            32'd4:   return 32'h01397AB3;
            32'd5:   return 32'h01802283;
            32'd6:   return 32'h01C02303;
            32'd7:   return 32'h0062E3B3;
            32'd9:   return 32'h00730663;
            32'd10:  return 32'h00802B03;
            32'd11:  return 32'h01690863;
            32'd14:  return 32'h00000663;
            32'd15:  return 32'h00002B03;
            32'd16:  return 32'hFF6B0CE3;
            default: return 32'h00000013;
        endcase
    endfunction

    // Depths are powers of two, so the low address bits give the wrapped word index
    assign imem_idx = pc[IAW+1:2];
    assign instr    = imem_rom(imem_idx);

    always_comb begin
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        use_imm   = 1'b0;
        alu_op    = ALU_ADD;
        imm_type  = IMM_I;
        case (instr[6:0])
            OP_LOAD: if (instr[14:12] == F3_LW) begin
                reg_we  = 1'b1;
                is_load = 1'b1;
                use_imm = 1'b1;
            end
            OP_STORE: if (instr[14:12] == F3_SW) begin
                mem_we   = 1'b1;
                use_imm  = 1'b1;
                imm_type = IMM_S;
            end
            OP_REG: if (instr[31:25] == F7_BASE) begin
                case (instr[14:12])
                    F3_ADD:  reg_we = 1'b1;
                    F3_AND:  begin reg_we = 1'b1; alu_op = ALU_AND; end
                    F3_OR:   begin reg_we = 1'b1; alu_op = ALU_OR;  end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_BRANCH: if (instr[14:12] == F3_BEQ) begin
                is_branch = 1'b1;
                imm_type  = IMM_B;
            end
            default: reg_we = 1'b0;
        endcase
    end

    assign imm   = imm_gen(instr, imm_type);
    assign alu_b = use_imm ? imm : rs2_val;

    always_comb begin
        case (alu_op)
            ALU_AND: alu_res = rs1_val & alu_b;
            ALU_OR:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val + alu_b;
        endcase
    end

    assign dmem_idx = alu_res[DAW+1:2];
    assign wb_data  = is_load ? load_data : alu_res;

    rv32i_regfile regfile_u (
        .clk    (clk),
        .rst    (rst_n),
        .we     (reg_we),
        .waddr  (instr[11:7]),
        .wdata  (wb_data),
        .raddr1 (instr[19:15]),
        .raddr2 (instr[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    // Data RAM keeps its image across reset; only the store on a reset edge is blocked
    if (1) begin : dmemory
        logic [31:0] mem [0:DMEM_WORDS-1] = '{
            0: 32'hAEAEAEAE, 1: 32'h00000000, 2: 32'hABCDEF11, 3: 32'hABCDEF11,
            4: 32'hF2F2F2F2, 5: 32'h12345678, 6: 32'h125F552D, 7: 32'h7F4FD46A,
            default: 32'h00000000
        };

        always_ff @(posedge clk) begin
            if (!rst_n && mem_we) begin
                mem[dmem_idx] <= rs2_val;
            end
        end
    end

    assign load_data = dmemory.mem[dmem_idx];

    assign pc_d = (is_branch && (rs1_val == rs2_val)) ? pc + imm : pc + 32'd4;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: tb/tb_rv32i_single_cycle_cpu.sv
// tb/tb_rv32i_single_cycle_cpu.sv - program trace and randomized reset/run-length checks against an instruction-level model
module tb_rv32i_single_cycle_cpu;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    logic [31:0] prog  [64];
    logic [31:0] m_x   [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_pc;

    rv32i_single_cycle_cpu dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, ii, si, bi, nxt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        ins = prog[(m_pc >> 2) % 64];
        op  = ins[6:0];
        f3  = ins[14:12];
        rd  = ins[11:7];
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        si  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        bi  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt = m_pc + 32'd4;
        if (op == 7'h03 && f3 == 3'd2) begin
            if (rd != 0) m_x[rd] = m_mem[((a + ii) >> 2) % 64];
        end else if (op == 7'h23 && f3 == 3'd2) begin
            m_mem[((a + si) >> 2) % 64] = b;
        end else if (op == 7'h33 && ins[31:25] == 7'd0 && rd != 0) begin
            if (f3 == 3'd0) m_x[rd] = a + b;
            else if (f3 == 3'd7) m_x[rd] = a & b;
            else if (f3 == 3'd6) m_x[rd] = a | b;
        end else if (op == 7'h63 && f3 == 3'd0 && a == b) begin
            nxt = m_pc + bi;
        end
        m_pc = nxt;
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            prog[i]  = 32'h00000013;
            m_mem[i] = 32'h0;
        end
        prog[0]  = 32'h00C02903; prog[1]  = 32'h01202823; prog[2]  = 32'h01402883;
        prog[3]  = 32'h011909B3; prog[4]  = 32'h01397AB3; prog[5]  = 32'h01802283;
        prog[6]  = 32'h01C02303; prog[7]  = 32'h0062E3B3; prog[9]  = 32'h00730663;
        prog[10] = 32'h00802B03; prog[11] = 32'h01690863; prog[14] = 32'h00000663;
        prog[15] = 32'h00002B03; prog[16] = 32'hFF6B0CE3;
        m_mem[0] = 32'hAEAEAEAE; m_mem[2] = 32'hABCDEF11; m_mem[3] = 32'hABCDEF11;
        m_mem[4] = 32'hF2F2F2F2; m_mem[5] = 32'h12345678; m_mem[6] = 32'h125F552D;
        m_mem[7] = 32'h7F4FD46A;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_pc", dut.pc, 32'h0);
        check("reset_x18", dut.regfile_u.registers[18], 32'h0);
        rst_n = 1'b0;

        for (int e = 1; e <= 15; e++) begin
            if (e == 2) check("pre_store_dmem4", dut.dmemory.mem[4], 32'hF2F2F2F2);
            step_edge();
            check("trace_pc", dut.pc, m_pc);
            case (e)
                1:  check("lw_x18", dut.regfile_u.registers[18], 32'hABCDEF11);
                2:  check("sw_dmem4", dut.dmemory.mem[4], 32'hABCDEF11);
                3:  check("lw_x17", dut.regfile_u.registers[17], 32'h12345678);
                4:  check("add_x19", dut.regfile_u.registers[19], 32'hBE024589);
                5:  check("and_x21", dut.regfile_u.registers[21], 32'hAA004501);
                6:  check("lw_x5", dut.regfile_u.registers[5], 32'h125F552D);
                7:  check("lw_x6", dut.regfile_u.registers[6], 32'h7F4FD46A);
                8:  check("or_x7", dut.regfile_u.registers[7], 32'h7F5FD56F);
                9:  check("nop_pc", dut.pc, 32'h24);
                10: check("beq_nt_pc", dut.pc, 32'h28);
                11: check("lw_x22", dut.regfile_u.registers[22], 32'hABCDEF11);
                12: check("beq_fwd_pc", dut.pc, 32'h3C);
                13: check("lw_x22_b", dut.regfile_u.registers[22], 32'hAEAEAEAE);
                14: check("beq_back_pc", dut.pc, 32'h38);
                15: check("beq_x0_pc", dut.pc, 32'h44);
                default: ;
            endcase
        end

        // Asynchronous reset between edges, then randomized run lengths with pc wrap-around
        for (int r = 0; r < 10; r++) begin
            #($urandom_range(1, 3));
            rst_n = 1'b1;
            #1;
            check("async_rst_pc", dut.pc, 32'h0);
            check("async_rst_x22", dut.regfile_u.registers[22], 32'h0);
            check("async_rst_x0", dut.regfile_u.registers[0], 32'h0);
            model_reset();
            @(negedge clk);
            if (r % 2 == 1) begin
                @(negedge clk);
                check("rst_hold_pc", dut.pc, 32'h0);
            end
            rst_n = 1'b0;
            for (int n = $urandom_range(1, 180); n > 0; n--) begin
                int ri;
                step_edge();
                ri = $urandom_range(0, 31);
                check("rand_pc", dut.pc, m_pc);
                check($sformatf("rand_x%0d", ri), dut.regfile_u.registers[ri], m_x[ri]);
            end
            for (int i = 0; i < 32; i++)
                check($sformatf("end_x%0d", i), dut.regfile_u.registers[i], m_x[i]);
            for (int i = 0; i < 8; i++)
                check($sformatf("end_mem%0d", i), dut.dmemory.mem[i], m_mem[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
